// File: rtl/alu_seq.sv
`default_nettype none
// ============================================================================
// Module   : alu_seq
// Brief    : Handshaked ALU. Add, sub, shift and logic ops finish in one cycle.
//            Multiply and divide are iterative and return a secondary result.
// Revision : 1.0
// ============================================================================
module alu_seq #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    input  logic             en,
    output wire  [WIDTH-1:0] f,
    output logic [WIDTH-1:0] hi,
    output logic [3:0]       flags
);

    localparam int SW = $clog2(WIDTH);

    localparam logic [1:0] C_IDLE = 2'd0;
    localparam logic [1:0] C_BUSY = 2'd1;
    localparam logic [1:0] C_DONE = 2'd2;

    localparam logic [2:0] C_OP_ADD = 3'b000;
    localparam logic [2:0] C_OP_SUB = 3'b001;
    localparam logic [2:0] C_OP_MUL = 3'b010;
    localparam logic [2:0] C_OP_DIV = 3'b011;
    localparam logic [2:0] C_OP_SHR = 3'b100;
    localparam logic [2:0] C_OP_SHL = 3'b101;
    localparam logic [2:0] C_OP_AND = 3'b110;
    localparam logic [2:0] C_OP_XOR = 3'b111;

    localparam logic [SW:0] C_CNT_MAX = WIDTH[SW:0];

    logic [1:0]       state_q, state_d;
    logic [SW:0]      cnt_q, cnt_d;
    logic [2:0]       op_q, op_d;
    logic [WIDTH-1:0] opb_q, opb_d;
    logic [WIDTH-1:0] acc_hi_q, acc_hi_d;
    logic [WIDTH-1:0] acc_lo_q, acc_lo_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [3:0]       flags_q, flags_d;

    logic             accept;
    logic             go_busy;
    logic [SW-1:0]    shamt;
    logic [WIDTH:0]   add_w, sub_w, shr_ext, shl_ext;
    logic [WIDTH-1:0] sc_f, sc_hi;
    logic             sc_c, sc_v, sc_dz;
    logic [WIDTH:0]   mul_sum, div_trial;

    assign accept  = in_valid && in_ready;
    assign go_busy = (op == C_OP_MUL) || ((op == C_OP_DIV) && (b != '0));

    assign f     = en ? result_q : {WIDTH{1'bz}};
    assign hi    = hi_q;
    assign flags = flags_q;

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= C_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            C_IDLE:  if (accept) state_d = go_busy ? C_BUSY : C_DONE;
            C_BUSY:  if (cnt_q == C_CNT_MAX) state_d = C_DONE;
            C_DONE:  if (out_ready) state_d = C_IDLE;
            default: state_d = C_IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        in_ready  = rst_n && (state_q == C_IDLE);
        out_valid = (state_q == C_DONE);
    end

    // Single-cycle results, evaluated directly from the live operands.
    always_comb begin
        shamt   = b[SW-1:0];
        add_w   = {1'b0, a} + {1'b0, b};
        sub_w   = {1'b0, a} - {1'b0, b};
        // The extra guard bit catches the last bit shifted out.
        shr_ext = {a, 1'b0} >> shamt;
        shl_ext = {1'b0, a} << shamt;
        sc_f    = '0;
        sc_hi   = '0;
        sc_c    = 1'b0;
        sc_v    = 1'b0;
        sc_dz   = 1'b0;
        case (op)
            C_OP_ADD: begin
                sc_f = add_w[WIDTH-1:0];
                sc_c = add_w[WIDTH];
                sc_v = (a[WIDTH-1] == b[WIDTH-1]) && (add_w[WIDTH-1] != a[WIDTH-1]);
            end
            C_OP_SUB: begin
                sc_f = sub_w[WIDTH-1:0];
                sc_c = sub_w[WIDTH];
                sc_v = (a[WIDTH-1] != b[WIDTH-1]) && (sub_w[WIDTH-1] != a[WIDTH-1]);
            end
            C_OP_DIV: begin
                if (b == '0) begin
                    sc_f  = '1;
                    sc_hi = a;
                    sc_dz = 1'b1;
                end
            end
            C_OP_SHR: begin
                sc_f = shr_ext[WIDTH:1];
                sc_c = shr_ext[0];
            end
            C_OP_SHL: begin
                sc_f = shl_ext[WIDTH-1:0];
                sc_c = shl_ext[WIDTH];
            end
            C_OP_AND: sc_f = a & b;
            C_OP_XOR: sc_f = a ^ b;
            default:  sc_f = '0;
        endcase
    end

    // acc_hi holds the product high half or the partial remainder; acc_lo
    // holds the multiplier being consumed or the quotient being built.
    always_comb begin
        mul_sum   = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, opb_q} : '0);
        div_trial = {acc_hi_q, acc_lo_q[WIDTH-1]} - {1'b0, opb_q};
    end

    always_comb begin
        cnt_d    = cnt_q;
        op_d     = op_q;
        opb_d    = opb_q;
        acc_hi_d = acc_hi_q;
        acc_lo_d = acc_lo_q;
        result_d = result_q;
        hi_d     = hi_q;
        flags_d  = flags_q;
        if (state_q == C_IDLE && accept) begin
            op_d     = op;
            opb_d    = b;
            cnt_d    = '0;
            acc_hi_d = '0;
            acc_lo_d = a;
            result_d = sc_f;
            hi_d     = sc_hi;
            flags_d  = {sc_dz, sc_v, sc_c, (sc_f == '0)};
        end else if (state_q == C_BUSY) begin
            if (cnt_q == C_CNT_MAX) begin
                result_d = acc_lo_q;
                hi_d     = acc_hi_q;
                flags_d  = {1'b0, (op_q == C_OP_MUL) && (acc_hi_q != '0), 1'b0,
                            (acc_lo_q == '0)};
            end else begin
                cnt_d = cnt_q + 1'b1;
                if (op_q == C_OP_MUL) begin
                    {acc_hi_d, acc_lo_d} = {mul_sum, acc_lo_q[WIDTH-1:1]};
                end else if (!div_trial[WIDTH]) begin
                    acc_hi_d = div_trial[WIDTH-1:0];
                    acc_lo_d = {acc_lo_q[WIDTH-2:0], 1'b1};
                end else begin
                    acc_hi_d = {acc_hi_q[WIDTH-2:0], acc_lo_q[WIDTH-1]};
                    acc_lo_d = {acc_lo_q[WIDTH-2:0], 1'b0};
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q    <= '0;
            op_q     <= '0;
            opb_q    <= '0;
            acc_hi_q <= '0;
            acc_lo_q <= '0;
            result_q <= '0;
            hi_q     <= '0;
            flags_q  <= '0;
        end else begin
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            opb_q    <= opb_d;
            acc_hi_q <= acc_hi_d;
            acc_lo_q <= acc_lo_d;
            result_q <= result_d;
            hi_q     <= hi_d;
            flags_q  <= flags_d;
        end
    end

endmodule
`default_nettype wire
